// File: rtl/conv2d_stream_engine.sv
// Clocked 2-D convolver: tap register file, one external pixel read per cycle, valid/ready
// result with floor shift and saturation. Define CONV_RELU_EN to clamp negative results to 0.
module conv2d_stream_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 10,
  parameter int MAX_IMG = 32,
  parameter int MAX_K   = 5,
  parameter int ADDR_W  = $clog2(MAX_IMG*MAX_IMG),
  parameter int TAP_AW  = $clog2(MAX_K*MAX_K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       img_size,
  input  logic [15:0]       filter_size,
  input  logic [1:0]        stride,
  input  logic              flt_we,
  input  logic [TAP_AW-1:0] flt_addr,
  input  logic [DATA_W-1:0] flt_data,
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NTAPS = MAX_K * MAX_K;
  localparam int ACC_W = 2*DATA_W + TAP_AW;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUTPUT, DONE} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] taps [NTAPS];
  logic [7:0]               cfg_n, cfg_k, o_last;
  logic [1:0]               cfg_s;
  logic [7:0]               kr, kc, orow, ocol, win_row, win_col;
  logic [TAP_AW-1:0]        t, tap_q;
  logic                     rd_q;
  logic signed [ACC_W-1:0]  acc;

  logic                     cfg_valid;
  logic [15:0]              diff, o_span;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next, shifted;
  logic                     fits;
  logic [DATA_W-1:0]        sat, result;
  logic [7:0]               s8;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] row, input logic [7:0] col,
                                                input logic [7:0] n);
    return ADDR_W'(row) * ADDR_W'(n) + ADDR_W'(col);
  endfunction

  assign s8 = {6'd0, cfg_s};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cfg_valid = (filter_size >= 16'd1) && (filter_size <= 16'(MAX_K)) &&
                (img_size >= filter_size) && (img_size <= 16'(MAX_IMG)) && (stride != 2'd0);
    diff      = img_size - filter_size;
    case (stride)
      2'd1:    o_span = diff;
      2'd2:    o_span = diff >> 1;
      default: o_span = diff / 16'd3;
    endcase

    prod = '0;
    if (rd_q) prod = $signed(img_data) * taps[tap_q];
    acc_next = acc + ACC_W'(prod);
    shifted  = acc_next >>> FRAC_W;
    // Fits in DATA_W when every bit above the result sign bit matches it.
    fits = (&shifted[ACC_W-1:DATA_W-1]) | ~(|shifted[ACC_W-1:DATA_W-1]);
    if (fits)                 sat = shifted[DATA_W-1:0];
    else if (shifted[ACC_W-1]) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                      sat = {1'b0, {(DATA_W-1){1'b1}}};
`ifdef CONV_RELU_EN
    result = sat[DATA_W-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      // NOTE: the tap file is a register array, so it can and must be cleared by reset.
      for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
      cfg_n <= '0; cfg_k <= '0; cfg_s <= '0; o_last <= '0;
      kr <= '0; kc <= '0; orow <= '0; ocol <= '0; win_row <= '0; win_col <= '0;
      t <= '0; tap_q <= '0; rd_q <= 1'b0; acc <= '0;
      img_rd <= 1'b0; img_addr <= '0; out_valid <= 1'b0; out_data <= '0;
      out_row <= '0; out_col <= '0; busy <= 1'b0; done <= 1'b0; err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout keep every register sampling pre-edge values.
      done <= 1'b0;
      err  <= 1'b0;
      if (flt_we && !busy && int'(flt_addr) < NTAPS) taps[flt_addr] <= flt_data;

      case (state)
        IDLE: if (start) begin
          if (!cfg_valid) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else begin
            cfg_n   <= img_size[7:0];
            cfg_k   <= filter_size[7:0];
            cfg_s   <= stride;
            o_last  <= o_span[7:0];
            kr <= '0; kc <= '0; t <= '0; rd_q <= 1'b0; acc <= '0;
            orow <= '0; ocol <= '0; win_row <= '0; win_col <= '0;
            img_rd   <= 1'b1;
            img_addr <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          rd_q  <= 1'b1;
          tap_q <= t;
          t     <= t + 1'b1;
          acc   <= acc_next;
          if (kc == cfg_k - 8'd1) begin
            kc <= '0;
            if (kr == cfg_k - 8'd1) begin
              img_rd <= 1'b0;
              state  <= DRAIN;
            end else begin
              kr       <= kr + 8'd1;
              img_addr <= addr_of(win_row + kr + 8'd1, win_col, cfg_n);
            end
          end else begin
            kc       <= kc + 8'd1;
            img_addr <= addr_of(win_row + kr, win_col + kc + 8'd1, cfg_n);
          end
        end

        DRAIN: begin
          acc       <= acc_next;
          rd_q      <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= result;
          out_row   <= orow;
          out_col   <= ocol;
          state     <= OUTPUT;
        end

        OUTPUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (orow == o_last && ocol == o_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (ocol == o_last) begin
              ocol     <= '0;
              win_col  <= '0;
              orow     <= orow + 8'd1;
              win_row  <= win_row + s8;
              img_addr <= addr_of(win_row + s8, 8'd0, cfg_n);
            end else begin
              ocol     <= ocol + 8'd1;
              win_col  <= win_col + s8;
              img_addr <= addr_of(win_row, win_col + s8, cfg_n);
            end
            kr <= '0; kc <= '0; t <= '0; acc <= '0;
            img_rd <= 1'b1;
            state  <= FETCH;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench for conv2d_stream_engine: a behavioural image buffer and a reference
// convolution model queue expected pixels at pass start; a monitor compares each transfer.
module tb_conv2d_stream_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] img_size = '0, filter_size = '0;
  logic [1:0]  stride = '0;
  logic        flt_we = 1'b0;
  logic [4:0]  flt_addr = '0;
  logic [15:0] flt_data = '0;
  logic        img_rd;
  logic [9:0]  img_addr;
  logic [15:0] img_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [7:0]  out_row, out_col;
  logic        busy, done, err;

  always #5 clk = ~clk;

  conv2d_stream_engine dut (
    .clk(clk), .reset(reset), .start(start), .img_size(img_size), .filter_size(filter_size),
    .stride(stride), .flt_we(flt_we), .flt_addr(flt_addr), .flt_data(flt_data),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .err(err)
  );

  logic signed [15:0] img_mem [1024];
  logic signed [15:0] tap_m [25];

  typedef struct {
    logic [15:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_out    = 0;

  always @(posedge clk) if (img_rd) img_data <= img_mem[img_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_row", 32'(out_row), 32'(e.row));
        check("out_col", 32'(out_col), 32'(e.col));
        n_out++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_px(input int n, input int k, input int s,
                                           input int r, input int c);
    longint a = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        a += longint'(img_mem[(r*s + i)*n + c*s + j]) * longint'(tap_m[i*k + j]);
    a = a >>> 10;
    if (a > 32767) a = 32767;
    else if (a < -32768) a = -32768;
`ifdef CONV_RELU_EN
    if (a < 0) a = 0;
`endif
    return 16'(a);
  endfunction

  task automatic push_expected(input int n, input int k, input int s);
    int o = (n - k) / s + 1;
    for (int r = 0; r < o; r++)
      for (int c = 0; c < o; c++) begin
        exp_t e;
        e.data = model_px(n, k, s, r, c);
        e.row  = 8'(r);
        e.col  = 8'(c);
        sb.push_back(e);
      end
  endtask

  task automatic fill_img(input int n, input int mode, input logic [15:0] val);
    for (int i = 0; i < n*n; i++)
      case (mode)
        0:       img_mem[i] = val;
        1:       img_mem[i] = 16'($urandom);
        default: img_mem[i] = 16'($urandom_range(0, 8191)) - 16'd4096;
      endcase
  endtask

  task automatic load_taps(input int k, input bit rnd, input logic [15:0] val);
    for (int i = 0; i < k*k; i++) begin
      flt_we   = 1'b1;
      flt_addr = 5'(i);
      flt_data = rnd ? 16'($urandom_range(0, 8191)) - 16'd4096 : val;
      tap_m[i] = flt_data;
      tick();
    end
    flt_we = 1'b0;
  endtask

  task automatic run_pass(input int n, input int k, input int s, input bit bp, input bit poke,
                          output int first_valid);
    int cyc = 1;
    bit seen = 0;
    logic [15:0] hd;
    logic [7:0] hr, hc;
    int o = (n - k) / s + 1;
    push_expected(n, k, s);
    n_out = 0;
    first_valid = -1;
    img_size = 16'(n); filter_size = 16'(k); stride = 2'(s);
    out_ready = !bp;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_cycle1", 32'(busy), 32'd1);
    while (!done && cyc < 20000) begin
      if (poke) begin
        flt_we   = (cyc == 3);
        start    = (cyc == 3);
        flt_addr = '0;
        flt_data = 16'h1234;
      end
      if (out_valid && !seen) begin
        seen = 1;
        first_valid = cyc;
        if (bp) begin
          hd = out_data; hr = out_row; hc = out_col;
          repeat (5) begin
            tick(); cyc++;
            check("bp_data", 32'(out_data), 32'(hd));
            check("bp_row", 32'(out_row), 32'(hr));
            check("bp_col", 32'(out_col), 32'(hc));
            check("bp_no_rd", 32'(img_rd), 32'd0);
          end
          out_ready = 1'b1;
        end
      end
      tick(); cyc++;
    end
    flt_we = 1'b0; start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("err_at_done", 32'(err), 32'd0);
    check("out_count", 32'(n_out), 32'(o*o));
    check("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
  endtask

  task automatic invalid_pass(input int n, input int k, input int s);
    bit saw_valid = 0, saw_rd = 0;
    img_size = 16'(n); filter_size = 16'(k); stride = 2'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("inv_done", 32'(done), 32'd1);
    check("inv_err", 32'(err), 32'd1);
    check("inv_busy", 32'(busy), 32'd0);
    tick();
    check("inv_done_pulse", 32'(done), 32'd0);
    repeat (20) begin
      saw_valid |= out_valid;
      saw_rd    |= img_rd;
      tick();
    end
    check("inv_no_valid", 32'(saw_valid), 32'd0);
    check("inv_no_rd", 32'(saw_rd), 32'd0);
  endtask

  initial begin
    int fv, cyc;
    bit saw_done;
    for (int i = 0; i < 1024; i++) img_mem[i] = '0;
    for (int i = 0; i < 25; i++) tap_m[i] = '0;

    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rd", 32'(img_rd), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_row", 32'(out_row), 32'd0);
    check("rst_col", 32'(out_col), 32'd0);
    reset = 1'b0;
    tick();

    // Unity pixels, 2.0 taps: every output is 18.0.
    fill_img(6, 0, 16'h0400);
    load_taps(3, 0, 16'h0800);
    run_pass(6, 3, 1, 0, 0, fv);
    check("first_valid_k3", 32'(fv), 32'd11);

    // One strongly negative pixel; busy tap write and start pokes must be ignored.
    img_mem[3] = 16'hA000;
    run_pass(6, 3, 1, 0, 1, fv);

    // Positive saturation with stride 2.
    fill_img(7, 0, 16'h7FFF);
    load_taps(3, 0, 16'h7FFF);
    run_pass(7, 3, 2, 0, 0, fv);

    // Backpressure on the first result.
    fill_img(6, 1, 16'h0);
    run_pass(6, 3, 1, 1, 0, fv);
    check("first_valid_bp", 32'(fv), 32'd11);

    // Mixed random data across sizes, strides and boundary filter sizes.
    fill_img(8, 2, 16'h0);
    load_taps(5, 1, 16'h0);
    run_pass(8, 5, 3, 0, 0, fv);
    check("first_valid_k5", 32'(fv), 32'd27);
    fill_img(5, 2, 16'h0);
    run_pass(5, 5, 1, 0, 0, fv);
    fill_img(4, 1, 16'h0);
    load_taps(1, 1, 16'h0);
    run_pass(4, 1, 2, 0, 0, fv);
    check("first_valid_k1", 32'(fv), 32'd3);
    fill_img(32, 2, 16'h0);
    load_taps(2, 1, 16'h0);
    run_pass(32, 2, 3, 0, 0, fv);

    invalid_pass(3, 4, 1);
    invalid_pass(6, 3, 0);
    invalid_pass(40, 3, 1);
    invalid_pass(6, 0, 1);
    invalid_pass(8, 6, 1);

    // Reset during the fifth output's fetch.
    fill_img(6, 0, 16'h0400);
    load_taps(3, 0, 16'h0800);
    push_expected(6, 3, 1);
    n_out = 0;
    img_size = 16'd6; filter_size = 16'd3; stride = 2'd1; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(n_out == 4 && img_rd) && cyc < 2000) begin
      tick(); cyc++;
    end
    check("rst_reach_5th", 32'(n_out), 32'd4);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 25; i++) tap_m[i] = '0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rd", 32'(img_rd), 32'd0);
    saw_done = 0;
    repeat (4) begin
      tick();
      saw_done |= done;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    // Taps were cleared, so this pass yields zeros; then reload and rerun.
    run_pass(6, 3, 1, 0, 0, fv);
    load_taps(3, 0, 16'h0800);
    run_pass(6, 3, 1, 0, 0, fv);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
